// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//
// Purpose:
//   Bundles the instruction-memory read port and the fetch-to-decode
//   valid/ready handshake of the fetch stage into one interface.
//
// Signals:
//   iren      - instruction memory read request (fetch -> memory)
//   iaddr     - word-aligned read address, the current PC (fetch -> memory)
//   iload     - read data, meaningful only when ramstate == ACCESS
//   ramstate  - memory status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   dec_valid - instr/pc/npc are valid (fetch -> decode)
//   dec_ready - decode can accept an instruction (decode -> fetch)
//   instr     - fetched instruction word
//   pc        - address of instr
//   npc       - pc + 4
//
// Modports:
//   master - the fetch stage
//   slave  - the environment (instruction memory plus decode)
// -----------------------------------------------------------------------------
interface fetch_stage_if;
    logic        iren;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic [1:0]  ramstate;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;

    modport master (
        output iren, iaddr, dec_valid, instr, pc, npc,
        input  iload, ramstate, dec_ready
    );

    modport slave (
        input  iren, iaddr, dec_valid, instr, pc, npc,
        output iload, ramstate, dec_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Purpose:
//   Instruction fetch stage of the single-issue RISC-V core. Holds the PC,
//   issues word reads to instruction memory, and presents each fetched
//   instruction with its PC to decode over a valid/ready handshake. Fetching
//   stops on a HALT opcode (instr[6:0] == 7'b1111111), a memory ERROR, a
//   misaligned redirect, or a memory-wait timeout.
//
// Parameters:
//   RESET_PC   - PC of the first fetch after reset (bits [1:0] must be 0)
//   WAIT_LIMIT - consecutive non-ACCESS cycles tolerated in FETCH (1..255)
//
// Ports:
//   CLK         - clock, rising edge
//   nRST        - asynchronous active-low reset
//   bus         - fetch_stage_if.master (memory port + decode handshake)
//   redirect    - branch/jump redirect from execute
//   redirect_pc - redirect target
//   halt        - sticky, fetch stopped
//   fault       - sticky, error stop (ERROR, timeout, misaligned redirect)
//   jal_taken   - only with FETCH_JAL_PREDECODE_EN: the presented JAL has
//                 already been redirected by fetch
//
// Build option:
//   FETCH_JAL_PREDECODE_EN - when defined, a JAL in HOLD steers the next
//   fetch to its target instead of pc+4 and raises jal_taken.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 16
) (
    input  logic                 CLK,
    input  logic                 nRST,
    fetch_stage_if.master        bus,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic                 halt,
    output logic                 fault
`ifdef FETCH_JAL_PREDECODE_EN
    ,
    output logic                 jal_taken
`endif
);

    localparam int              CW       = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0]   WAIT_MAX = CW'(WAIT_LIMIT);
    localparam logic [6:0]      OP_HALT  = 7'b1111111;
`ifdef FETCH_JAL_PREDECODE_EN
    localparam logic [6:0]      OP_JAL   = 7'b1101111;
`endif

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        START  = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t         state_q,    state_d;
    logic [31:0]    fetchPc_q,  fetchPc_d;
    logic [CW-1:0]  wait_q,     wait_d;
    logic [31:0]    instr_q,    instr_d;
    logic [31:0]    outPc_q,    outPc_d;
    logic [31:0]    npc_q,      npc_d;
    logic           decValid_q, decValid_d;
    logic           halt_q,     halt_d;
    logic           fault_q,    fault_d;
`ifdef FETCH_JAL_PREDECODE_EN
    logic           jal_q,      jal_d;
    logic [31:0]    jalImm;
`endif

    ramstate_t      memState;

    assign memState = ramstate_t'(bus.ramstate);

`ifdef FETCH_JAL_PREDECODE_EN
    // J-type immediate of the instruction currently held for decode.
    assign jalImm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                     instr_q[20], instr_q[30:21], 1'b0};
`endif

    // State and datapath registers. Everything visible to decode comes
    // straight from these flops, so dec_valid never depends combinationally
    // on dec_ready or redirect.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= START;
            fetchPc_q  <= RESET_PC;
            wait_q     <= '0;
            instr_q    <= '0;
            outPc_q    <= '0;
            npc_q      <= '0;
            decValid_q <= 1'b0;
            halt_q     <= 1'b0;
            fault_q    <= 1'b0;
`ifdef FETCH_JAL_PREDECODE_EN
            jal_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetchPc_q  <= fetchPc_d;
            wait_q     <= wait_d;
            instr_q    <= instr_d;
            outPc_q    <= outPc_d;
            npc_q      <= npc_d;
            decValid_q <= decValid_d;
            halt_q     <= halt_d;
            fault_q    <= fault_d;
`ifdef FETCH_JAL_PREDECODE_EN
            jal_q      <= jal_d;
`endif
        end
    end

    // Next-state logic. A redirect outranks everything in the live states;
    // in HALTED the stage is frozen until reset and ignores redirects.
    always_comb begin
        state_d    = state_q;
        fetchPc_d  = fetchPc_q;
        wait_d     = wait_q;
        instr_d    = instr_q;
        outPc_d    = outPc_q;
        npc_d      = npc_q;
        decValid_d = decValid_q;
        halt_d     = halt_q;
        fault_d    = fault_q;
`ifdef FETCH_JAL_PREDECODE_EN
        jal_d      = jal_q;
`endif

        if (redirect && (state_q != HALTED)) begin
            // Any pending presentation or in-flight read is dropped. A
            // transfer accepted this same cycle still counts on the decode
            // side; squashing it is the hazard unit's problem.
            decValid_d = 1'b0;
`ifdef FETCH_JAL_PREDECODE_EN
            jal_d      = 1'b0;
`endif
            if (redirect_pc[1:0] == 2'b00) begin
                fetchPc_d = redirect_pc;
                wait_d    = '0;
                state_d   = FETCH;
            end else begin
                fault_d = 1'b1;
                halt_d  = 1'b1;
                state_d = HALTED;
            end
        end else begin
            case (state_q)
                START: begin
                    state_d = FETCH;
                end

                FETCH: begin
                    case (memState)
                        ACCESS: begin
                            instr_d    = bus.iload;
                            outPc_d    = fetchPc_q;
                            npc_d      = fetchPc_q + 32'd4;
                            decValid_d = 1'b1;
`ifdef FETCH_JAL_PREDECODE_EN
                            jal_d      = (bus.iload[6:0] == OP_JAL);
`endif
                            state_d    = HOLD;
                        end
                        ERROR: begin
                            fault_d = 1'b1;
                            halt_d  = 1'b1;
                            state_d = HALTED;
                        end
                        default: begin
                            // Saturating wait count; reaching the limit is
                            // treated as a hung memory.
                            wait_d = (wait_q == WAIT_MAX) ? wait_q
                                                          : wait_q + 1'b1;
                            if (wait_d == WAIT_MAX) begin
                                fault_d = 1'b1;
                                halt_d  = 1'b1;
                                state_d = HALTED;
                            end
                        end
                    endcase
                end

                HOLD: begin
                    // decValid_q is always set here, so dec_ready alone
                    // marks the transfer.
                    if (bus.dec_ready) begin
                        decValid_d = 1'b0;
`ifdef FETCH_JAL_PREDECODE_EN
                        jal_d      = 1'b0;
`endif
                        if (instr_q[6:0] == OP_HALT) begin
                            halt_d  = 1'b1;
                            state_d = HALTED;
                        end else begin
`ifdef FETCH_JAL_PREDECODE_EN
                            fetchPc_d = jal_q ? (outPc_q + jalImm) : npc_q;
`else
                            fetchPc_d = npc_q;
`endif
                            wait_d    = '0;
                            state_d   = FETCH;
                        end
                    end
                end

                default: begin
                    state_d = HALTED;
                end
            endcase
        end
    end

    // Memory requests are only made while waiting for a word in FETCH.
    assign bus.iren      = (state_q == FETCH);
    assign bus.iaddr     = fetchPc_q;
    assign bus.dec_valid = decValid_q;
    assign bus.instr     = instr_q;
    assign bus.pc        = outPc_q;
    assign bus.npc       = npc_q;
    assign halt          = halt_q;
    assign fault         = fault_q;
`ifdef FETCH_JAL_PREDECODE_EN
    assign jal_taken     = jal_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed, table-driven bench for fetch_stage. Each table row is one clock
// cycle: the memory/decode/redirect inputs driven during that cycle and the
// outputs expected in that cycle. Multi-cycle corners (timeout, ERROR,
// misaligned redirect, JAL predecode, asynchronous reset) are hand-written.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;
    localparam int         WAIT_LIM  = 16;

    typedef struct {
        logic [1:0]  rs;
        logic [31:0] iload;
        logic        rdir;
        logic [31:0] rpc;
        logic        rdy;
        logic        eIren;
        logic [31:0] eIaddr;
        logic        eDv;
        logic [31:0] eInstr;
        logic [31:0] ePc;
        logic [31:0] eNpc;
        logic        eHalt;
        logic        eFault;
    } vec_t;

    logic        CLK;
    logic        nRST;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fault;
`ifdef FETCH_JAL_PREDECODE_EN
    logic        jal_taken;
`endif

    int nVec  = 0;
    int nMiss = 0;

    vec_t tbl[$];

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .WAIT_LIMIT (WAIT_LIM)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .fault       (fault)
`ifdef FETCH_JAL_PREDECODE_EN
        ,
        .jal_taken   (jal_taken)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop in case a sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mkVec(
        input logic [1:0] rs, input logic [31:0] iload, input logic rdir,
        input logic [31:0] rpc, input logic rdy,
        input logic eIren, input logic [31:0] eIaddr, input logic eDv,
        input logic [31:0] eInstr, input logic [31:0] ePc,
        input logic [31:0] eNpc, input logic eHalt, input logic eFault);
        vec_t v;
        v.rs = rs; v.iload = iload; v.rdir = rdir; v.rpc = rpc; v.rdy = rdy;
        v.eIren = eIren; v.eIaddr = eIaddr; v.eDv = eDv; v.eInstr = eInstr;
        v.ePc = ePc; v.eNpc = eNpc; v.eHalt = eHalt; v.eFault = eFault;
        return v;
    endfunction

    task automatic applyStimulus(input logic [1:0] rs, input logic [31:0] iload,
                                 input logic rdir, input logic [31:0] rpc,
                                 input logic rdy);
        bus.ramstate  = rs;
        bus.iload     = iload;
        redirect      = rdir;
        redirect_pc   = rpc;
        bus.dec_ready = rdy;
    endtask

    task automatic checkOutput(input string name, input int tag,
                               input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s (step %0d): got %h, expected %h",
                     name, tag, act, exp);
        end
    endtask

    task automatic checkRow(input int tag, input vec_t v);
        checkOutput("iren",      tag, 32'(bus.iren),      32'(v.eIren));
        checkOutput("iaddr",     tag, bus.iaddr,          v.eIaddr);
        checkOutput("dec_valid", tag, 32'(bus.dec_valid), 32'(v.eDv));
        checkOutput("instr",     tag, bus.instr,          v.eInstr);
        checkOutput("pc",        tag, bus.pc,             v.ePc);
        checkOutput("npc",       tag, bus.npc,            v.eNpc);
        checkOutput("halt",      tag, 32'(halt),          32'(v.eHalt));
        checkOutput("fault",     tag, 32'(fault),         32'(v.eFault));
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, and releases
    // at a falling edge so the caller starts in the START cycle.
    task automatic doReset(input int tag);
        applyStimulus(RS_FREE, 32'h0, 1'b0, 32'h0, 1'b0);
        #2 nRST = 1'b0;
        #1;
        checkOutput("rst_iren",  tag, 32'(bus.iren),      32'h0);
        checkOutput("rst_dv",    tag, 32'(bus.dec_valid), 32'h0);
        checkOutput("rst_instr", tag, bus.instr,          32'h0);
        checkOutput("rst_pc",    tag, bus.pc,             32'h0);
        checkOutput("rst_npc",   tag, bus.npc,            32'h0);
        checkOutput("rst_iaddr", tag, bus.iaddr,          32'h0);
        checkOutput("rst_halt",  tag, 32'(halt),          32'h0);
        checkOutput("rst_fault", tag, 32'(fault),         32'h0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b1;
        applyStimulus(RS_FREE, 32'h0, 1'b0, 32'h0, 1'b0);

        // rs, iload, rdir, rpc, rdy | iren, iaddr, dv, instr, pc, npc, halt, fault
        // Straight-line fetch of two NOPs with decode always ready.
        tbl.push_back(mkVec(RS_ACCESS, 32'h13, 0, 0, 1,  0, 32'h0, 0, 32'h0,  32'h0, 32'h0, 0, 0));
        tbl.push_back(mkVec(RS_ACCESS, 32'h13, 0, 0, 1,  1, 32'h0, 0, 32'h0,  32'h0, 32'h0, 0, 0));
        tbl.push_back(mkVec(RS_FREE,   32'h0,  0, 0, 1,  0, 32'h0, 1, 32'h13, 32'h0, 32'h4, 0, 0));
        tbl.push_back(mkVec(RS_ACCESS, 32'h13, 0, 0, 1,  1, 32'h4, 0, 32'h13, 32'h0, 32'h4, 0, 0));
        tbl.push_back(mkVec(RS_FREE,   32'h0,  0, 0, 1,  0, 32'h4, 1, 32'h13, 32'h4, 32'h8, 0, 0));
        // ACCESS at 0x8 together with a redirect to 0x100: data dropped.
        tbl.push_back(mkVec(RS_ACCESS, 32'h1234_5013, 1, 32'h100, 1,  1, 32'h8, 0, 32'h13, 32'h4, 32'h8, 0, 0));
        // BUSY three cycles at 0x100, then ACCESS.
        tbl.push_back(mkVec(RS_BUSY,   32'h0,  0, 0, 0,  1, 32'h100, 0, 32'h13, 32'h4, 32'h8, 0, 0));
        tbl.push_back(mkVec(RS_BUSY,   32'h0,  0, 0, 0,  1, 32'h100, 0, 32'h13, 32'h4, 32'h8, 0, 0));
        tbl.push_back(mkVec(RS_BUSY,   32'h0,  0, 0, 0,  1, 32'h100, 0, 32'h13, 32'h4, 32'h8, 0, 0));
        tbl.push_back(mkVec(RS_ACCESS, 32'h0050_0093, 0, 0, 0,  1, 32'h100, 0, 32'h13, 32'h4, 32'h8, 0, 0));
        // Decode stalls five cycles: presentation must stay stable.
        for (int i = 0; i < 5; i++)
            tbl.push_back(mkVec(RS_FREE, 32'h0, 0, 0, 0,  0, 32'h100, 1, 32'h0050_0093, 32'h100, 32'h104, 0, 0));
        tbl.push_back(mkVec(RS_FREE,   32'h0,  0, 0, 1,  0, 32'h100, 1, 32'h0050_0093, 32'h100, 32'h104, 0, 0));
        // Next fetch is 0x104; redirect it to 0x20 where a HALT sits.
        tbl.push_back(mkVec(RS_FREE,   32'h0,  1, 32'h20, 0,  1, 32'h104, 0, 32'h0050_0093, 32'h100, 32'h104, 0, 0));
        tbl.push_back(mkVec(RS_ACCESS, 32'hFFFF_FFFF, 0, 0, 1,  1, 32'h20, 0, 32'h0050_0093, 32'h100, 32'h104, 0, 0));
        tbl.push_back(mkVec(RS_FREE,   32'h0,  0, 0, 1,  0, 32'h20, 1, 32'hFFFF_FFFF, 32'h20, 32'h24, 0, 0));
        // Halted: redirects to 0x0 are ignored.
        tbl.push_back(mkVec(RS_FREE,   32'h0,  1, 32'h0, 1,  0, 32'h20, 0, 32'hFFFF_FFFF, 32'h20, 32'h24, 1, 0));
        tbl.push_back(mkVec(RS_ACCESS, 32'h13, 1, 32'h0, 0,  0, 32'h20, 0, 32'hFFFF_FFFF, 32'h20, 32'h24, 1, 0));
        tbl.push_back(mkVec(RS_FREE,   32'h0,  0, 0, 0,  0, 32'h20, 0, 32'hFFFF_FFFF, 32'h20, 32'h24, 1, 0));

        @(negedge CLK);
        doReset(0);
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].rs, tbl[i].iload, tbl[i].rdir, tbl[i].rpc, tbl[i].rdy);
            checkRow(i, tbl[i]);
            @(negedge CLK);
        end

        // Memory never answers: timeout after WAIT_LIM BUSY cycles in FETCH.
        doReset(100);
        checkOutput("to_start_iren", 100, 32'(bus.iren), 32'h0);
        @(negedge CLK);
        for (int k = 1; k <= WAIT_LIM; k++) begin
            applyStimulus(RS_BUSY, 32'h0, 1'b0, 32'h0, 1'b0);
            checkOutput("to_wait_iren",  100 + k, 32'(bus.iren), 32'h1);
            checkOutput("to_wait_fault", 100 + k, 32'(fault),    32'h0);
            @(negedge CLK);
        end
        checkOutput("to_fault", 200, 32'(fault),         32'h1);
        checkOutput("to_halt",  200, 32'(halt),          32'h1);
        checkOutput("to_iren",  200, 32'(bus.iren),      32'h0);
        checkOutput("to_dv",    200, 32'(bus.dec_valid), 32'h0);

        // Misaligned redirect during FETCH.
        doReset(300);
        @(negedge CLK);
        applyStimulus(RS_BUSY, 32'h0, 1'b1, 32'h102, 1'b0);
        checkOutput("mis_iren_before", 300, 32'(bus.iren), 32'h1);
        checkOutput("mis_fault_before", 300, 32'(fault),   32'h0);
        @(negedge CLK);
        applyStimulus(RS_FREE, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("mis_fault", 301, 32'(fault),    32'h1);
        checkOutput("mis_halt",  301, 32'(halt),     32'h1);
        checkOutput("mis_iren",  301, 32'(bus.iren), 32'h0);

        // Memory ERROR: stop without presenting anything.
        doReset(400);
        @(negedge CLK);
        applyStimulus(RS_ERROR, 32'h13, 1'b0, 32'h0, 1'b1);
        @(negedge CLK);
        applyStimulus(RS_FREE, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("err_fault", 401, 32'(fault),         32'h1);
        checkOutput("err_halt",  401, 32'(halt),          32'h1);
        checkOutput("err_dv",    401, 32'(bus.dec_valid), 32'h0);
        checkOutput("err_iren",  401, 32'(bus.iren),      32'h0);

        // JAL +0x40 at 0x10, reached by a redirect issued in START.
        doReset(500);
        applyStimulus(RS_FREE, 32'h0, 1'b1, 32'h10, 1'b0);
        @(negedge CLK);
        applyStimulus(RS_ACCESS, 32'h0400_00EF, 1'b0, 32'h0, 1'b0);
        checkOutput("jal_iaddr", 501, bus.iaddr,     32'h10);
        checkOutput("jal_iren",  501, 32'(bus.iren), 32'h1);
        @(negedge CLK);
        applyStimulus(RS_FREE, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("jal_dv",    502, 32'(bus.dec_valid), 32'h1);
        checkOutput("jal_pc",    502, bus.pc,             32'h10);
        checkOutput("jal_npc",   502, bus.npc,            32'h14);
        checkOutput("jal_instr", 502, bus.instr,          32'h0400_00EF);
`ifdef FETCH_JAL_PREDECODE_EN
        checkOutput("jal_taken", 502, 32'(jal_taken),     32'h1);
`endif
        @(negedge CLK);
        applyStimulus(RS_FREE, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("jal_next_iren", 503, 32'(bus.iren), 32'h1);
`ifdef FETCH_JAL_PREDECODE_EN
        checkOutput("jal_next_iaddr", 503, bus.iaddr, 32'h50);
        checkOutput("jal_taken_clr",  503, 32'(jal_taken), 32'h0);
`else
        checkOutput("jal_next_iaddr", 503, bus.iaddr, 32'h14);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the single-issue RISC-V core.
- Holds the PC and issues word reads to instruction memory over the iren/iaddr/iload/ramstate interface.
- Presents each fetched instruction and its PC to decode through a valid/ready handshake.
- Stops fetching on a HALT opcode, a memory error, a misaligned redirect, or a memory-wait timeout.

Parameters:
- RESET_PC, 32'h0000_0000: PC of the first fetch after reset; bits [1:0] must be 0.
- WAIT_LIMIT, 16: consecutive non-ACCESS cycles tolerated in FETCH before a timeout fault; legal range 1..255.

Ports:
- CLK in 1: clock, rising edge.
- nRST in 1: asynchronous active-low reset.
- iren out 1: instruction memory read request.
- iaddr out 32: word-aligned read address (the PC).
- iload in 32: read data; valid only when ramstate==ACCESS.
- ramstate in 2: memory status, ramstate_t encoding FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- redirect in 1: branch/jump redirect from execute.
- redirect_pc in 32: redirect target.
- dec_ready in 1: decode can accept an instruction.
- dec_valid out 1: instr/pc/npc outputs valid.
- instr out 32: fetched instruction word.
- pc out 32: address of instr.
- npc out 32: pc + 4, modulo 2^32.
- halt out 1: sticky; fetch stopped.
- fault out 1: sticky; error stop (ERROR, timeout or misaligned redirect).

Behaviour:
- Reset (asynchronous, nRST=0):
  - state=START, PC=RESET_PC, wait counter=0.
  - iren=0, dec_valid=0, instr=0, pc=0, npc=0, halt=0, fault=0.
- States and transitions:
  - START: one cycle, iren=0. Always goes to FETCH.
  - FETCH: iren=1, iaddr=PC.
    - ramstate==ACCESS: latch instr=iload, pc=PC, npc=PC+4; next cycle dec_valid=1 and state=HOLD. Latency is ACCESS cycle N → dec_valid in N+1.
    - ramstate==BUSY or FREE: counter+1. When the counter reaches WAIT_LIMIT: fault=1, go to HALTED.
    - ramstate==ERROR: fault=1, go to HALTED. No instruction is presented.
  - HOLD: iren=0; instr/pc/npc stay stable while dec_valid=1.
    - On dec_valid&dec_ready: dec_valid=0 next cycle.
      - If instr[6:0]==HALT (7'b1111111): halt=1, go to HALTED.
      - Otherwise PC=npc, counter=0, go to FETCH.
    - The HALT instruction itself is always presented and transferred to decode.
  - HALTED: iren=0, dec_valid=0. Stays here until reset; redirect is ignored.
- Redirect (highest priority in START, FETCH and HOLD):
  - redirect_pc[1:0]==0: PC=redirect_pc, counter=0, dec_valid=0 next cycle, go to FETCH.
  - redirect_pc[1:0]!=0: fault=1, go to HALTED.
  - Redirect in the same cycle as ACCESS: the returned iload is discarded and the next fetch uses the target.
  - Redirect in the same cycle as dec_valid&dec_ready: the transfer counts on the decode side (squashing it is the hazard unit's job); fetch still goes to the target.
- Handshake rules:
  - dec_valid is driven from a register, never combinationally from dec_ready or redirect.
  - dec_valid, once high, stays high with stable data until a transfer or a redirect.
- Arithmetic: PC increments wrap 32'hFFFF_FFFC → 32'h0000_0000.
- Timeout counter: width $clog2(WAIT_LIMIT+1); saturates and never wraps.

Optional Feature:
- Macro FETCH_JAL_PREDECODE_EN.
- Defined:
  - In HOLD, if instr[6:0]==JAL (7'b1101111), the PC after transfer is pc + sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}) instead of npc.
  - npc output still reports pc+4 as the link value.
  - Adds one output, jal_taken (1 bit): high with dec_valid when this redirect is applied, so execute can suppress its own JAL redirect.
- Undefined: JAL follows the normal pc+4 path, jal_taken is absent, and execute redirects.

Test Plan:
- Reset release, memory returns ACCESS immediately with 32'h00000013 at 0x0 and 0x4, dec_ready=1 → iaddr sequence 0x0, 0x4, 0x8; dec_valid pulses with pc=0x0/npc=0x4, then pc=0x4/npc=0x8.
- Memory BUSY for 3 cycles then ACCESS, dec_ready held low 5 cycles → dec_valid stays 1 and instr/pc stay stable for those 5 cycles; next iaddr=PC+4 only after the transfer.
- Redirect to 0x100 in the same cycle as ACCESS at 0x8 → data at 0x8 never reaches decode; next iaddr=0x100.
- Fetch of 32'hFFFF_FFFF (HALT) at 0x20 → presented with pc=0x20; halt=1 after transfer; iren=0 afterwards; a later redirect to 0x0 has no effect.
- ramstate BUSY for WAIT_LIMIT=16 cycles → fault=1 and halt=1 on the 16th, iren=0; separately, redirect_pc=0x102 → fault=1 and halt=1 next cycle.
- FETCH_JAL_PREDECODE_EN defined, JAL +0x40 (32'h040000EF) at 0x10 → jal_taken=1, npc=0x14, next iaddr=0x50. Undefined → next iaddr=0x14.
